adc_stream_top: RTL and testbench
=================================

Name: adc_stream_top

Overview:
Single-clock core of the AD9643 dual-channel 14-bit ADC capture path. It takes already-deserialized channel A/B sample pairs and the ADC overrange flag, and forwards the samples as two lock-stepped AXI4-Stream channels. An AXI4-Lite slave register file provides enable, format and status control. LVDS/IDDR capture and clock-domain crossing are handled upstream of this block.

Parameters:
DATA_WIDTH, 14, ADC sample width
TDATA_WIDTH, 16, stream data width (≥ DATA_WIDTH)

Ports:
aclk  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
adc_data_a  in  DATA_WIDTH  channel A sample (offset binary)
adc_data_b  in  DATA_WIDTH  channel B sample (offset binary)
adc_valid  in  1  sample pair valid this cycle
adc_or  in  1  ADC overrange flag
s_axi_awaddr  in  32  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid/s_axi_awready  in/out  1  write address handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_wvalid/s_axi_wready  in/out  1  write data handshake
s_axi_bresp  out  2  write response
s_axi_bvalid/s_axi_bready  out/in  1  write response handshake
s_axi_araddr  in  32  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid/s_axi_arready  in/out  1  read address handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid/s_axi_rready  out/in  1  read data handshake
adc_ready  out  1  registered copy of CTRL.ENABLE
m_axis_tvalid_chA  out  1  channel A valid
m_axis_tdata_chA  out  TDATA_WIDTH  channel A data
m_axis_tvalid_chB  out  1  channel B valid
m_axis_tdata_chB  out  TDATA_WIDTH  channel B data
m_axis_tready  in  1  ready, shared by both channels

Behaviour:
- Reset: all outputs 0; all registers and counters 0.
- AXI-Lite write:
  - awready and wready pulse together for one cycle when awvalid && wvalid && !bvalid.
  - bvalid rises the next cycle and holds until bready.
  - bresp is 00 for mapped addresses, 10 (SLVERR) for unmapped; unmapped writes have no effect.
  - wstrb gates each byte.
- AXI-Lite read:
  - arready pulses for one cycle when arvalid && !rvalid.
  - rvalid rises the next cycle; rdata/rresp are held stable until rready.
  - Unmapped reads return 0 with rresp 10.
- Address decode uses addr[7:2]. Register map:
  - 0x00 CTRL (RW):
    - bit0 ENABLE.
    - bit1 OR_CLR: write-1 clears OR_STICKY; not stored, reads 0.
    - bit2 TWOS: output in two's complement.
    - Other bits read 0.
  - 0x04 STATUS (RO):
    - bit0 OR_STICKY.
    - bit1 adc_ready.
    - [31:16] DROP_CNT, saturates at 0xFFFF.
  - 0x08 SAMPLE_CNT (RO): count of accepted beats, 32-bit, wraps.
- OR_STICKY:
  - Set in any cycle where adc_or=1, independent of ENABLE.
  - If set and clear occur in the same cycle, set wins.
- Datapath:
  - Conversion: x' = TWOS ? {~x[MSB], x[MSB-1:0]} : x.
  - Extension to TDATA_WIDTH: sign-extend when TWOS=1, zero-extend otherwise. Both channels use the same conversion.
- Stream output stage (1-entry register per channel, shared valid):
  - A sample pair is accepted when adc_valid && ENABLE && (!tvalid || tready). The output is loaded next cycle: latency 1, tvalid=1.
  - tvalid_chA ≡ tvalid_chB at all times.
  - A beat completes when tvalid && tready; tvalid falls next cycle unless a new pair is loaded the same cycle. Back-to-back beats run at 1 per cycle.
  - If tvalid && !tready && adc_valid && ENABLE: the new pair is dropped, DROP_CNT++, and the held data stays stable.
  - SAMPLE_CNT++ on each completed beat.
  - ENABLE cleared while tvalid=1: the pending beat is held until accepted; no new loads.
  - adc_valid while ENABLE=0: ignored, not counted.
- adc_ready = CTRL.ENABLE, registered, 1 cycle after the write.

Test Plan:
- Reset, then read 0x00/0x04/0x08 → all 0, rresp 00; read 0x0C → rdata 0, rresp 10.
- Write 0x01234561 to 0x00, read 0x00 → 0x00000001, adc_ready=1; then write 0x89ABCDE2 → ENABLE=0, adc_ready=0, OR_STICKY cleared.
- ENABLE=1, tready=1, ramp input a=n, b=~n&0x3FFF → tdata_chA=n one cycle after input; SAMPLE_CNT counts each beat.
- TWOS=1, input a=0x0000 → tdata 0xE000; input a=0x3FFF → tdata 0x1FFF.
- Hold tready low for 200 cycles with continuous adc_valid → data held stable; DROP_CNT=199 (first pair loaded, 199 dropped); SAMPLE_CNT increments by 1 when tready rises.
- Pulse adc_or for 1 cycle → STATUS bit0=1 and stays 1; write CTRL bit1 → bit0=0; set and clear in the same cycle → stays 1.

Source files
------------

// File: rtl/adc_stream_top.sv
// AD9643 capture core: converts deserialized A/B sample pairs into two lock-stepped
// AXI4-Stream channels, with an AXI4-Lite register file for control and status.
module adc_stream_top #(
    parameter int DATA_WIDTH  = 14,
    parameter int TDATA_WIDTH = 16
) (
    input  logic                   aclk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  adc_data_a,
    input  logic [DATA_WIDTH-1:0]  adc_data_b,
    input  logic                   adc_valid,
    input  logic                   adc_or,
    input  logic [31:0]            s_axi_awaddr,
    input  logic [2:0]             s_axi_awprot,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [31:0]            s_axi_wdata,
    input  logic [3:0]             s_axi_wstrb,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    output logic [1:0]             s_axi_bresp,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    input  logic [31:0]            s_axi_araddr,
    input  logic [2:0]             s_axi_arprot,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    output logic [31:0]            s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    output logic                   adc_ready,
    output logic                   m_axis_tvalid_chA,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata_chA,
    output logic                   m_axis_tvalid_chB,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata_chB,
    input  logic                   m_axis_tready
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic        enable, twos, or_sticky, tvalid;
    logic [15:0] drop_cnt;
    logic [31:0] sample_cnt;
    logic        wr_hs, rd_hs, ctrl_wr, or_clr, rd_map;
    logic [31:0] rd_val;
    logic        accept, drop;
    logic        unused_bits;

    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[31:8], s_axi_awaddr[1:0],
                           s_axi_araddr[31:8], s_axi_araddr[1:0], s_axi_wdata[31:3], s_axi_wstrb[3:1]};

    // Offset binary to two's complement is an MSB flip; extension follows the chosen format.
    function automatic logic [TDATA_WIDTH-1:0] fmt(input logic [DATA_WIDTH-1:0] x, input logic tc);
        logic [DATA_WIDTH-1:0] c;
        c = x;
        if (tc) begin
            c[DATA_WIDTH-1] = ~x[DATA_WIDTH-1];
            fmt = TDATA_WIDTH'(signed'(c));
        end else begin
            fmt = TDATA_WIDTH'(c);
        end
    endfunction

    assign wr_hs   = s_axi_awready && s_axi_awvalid && s_axi_wvalid;
    assign rd_hs   = s_axi_arready && s_axi_arvalid;
    assign ctrl_wr = wr_hs && (s_axi_awaddr[7:2] == 6'd0) && s_axi_wstrb[0];
    assign or_clr  = ctrl_wr && s_axi_wdata[1];

    always_comb begin
        rd_val = '0;
        rd_map = 1'b1;
        case (s_axi_araddr[7:2])
            6'd0:    rd_val = {29'd0, twos, 1'b0, enable};
            6'd1:    rd_val = {drop_cnt, 14'd0, adc_ready, or_sticky};
            6'd2:    rd_val = sample_cnt;
            default: rd_map = 1'b0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            enable        <= 1'b0;
            twos          <= 1'b0;
            adc_ready     <= 1'b0;
            or_sticky     <= 1'b0;
        end else begin
            // Ready is a single-cycle pulse; the !ready term stops a second accept of the same request.
            s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
            s_axi_wready  <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
            if (wr_hs) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= (s_axi_awaddr[7:2] < 6'd3) ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
            if (ctrl_wr) begin
                enable <= s_axi_wdata[0];
                twos   <= s_axi_wdata[2];
            end

            s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
            if (rd_hs) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_val;
                s_axi_rresp  <= rd_map ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end

            adc_ready <= enable;
            if (adc_or)      or_sticky <= 1'b1;
            else if (or_clr) or_sticky <= 1'b0;
        end
    end

    assign accept = adc_valid && enable && (!tvalid || m_axis_tready);
    assign drop   = adc_valid && enable && tvalid && !m_axis_tready;

    always_ff @(posedge aclk) begin
        if (reset) begin
            tvalid           <= 1'b0;
            m_axis_tdata_chA <= '0;
            m_axis_tdata_chB <= '0;
            drop_cnt         <= '0;
            sample_cnt       <= '0;
        end else begin
            if (accept) begin
                tvalid           <= 1'b1;
                m_axis_tdata_chA <= fmt(adc_data_a, twos);
                m_axis_tdata_chB <= fmt(adc_data_b, twos);
            end else if (m_axis_tready) begin
                tvalid <= 1'b0;
            end
            if (tvalid && m_axis_tready)       sample_cnt <= sample_cnt + 32'd1;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt   <= drop_cnt + 16'd1;
        end
    end

    assign m_axis_tvalid_chA = tvalid;
    assign m_axis_tvalid_chB = tvalid;

endmodule

// File: tb/tb_adc_stream_top.sv
// Bench for adc_stream_top: a spec-level model checked every cycle, plus directed
// register and stream scenarios with hand-computed expectations.
module tb_adc_stream_top;
    localparam int DW = 14;
    localparam int TW = 16;
    localparam int NLIT = 256;

    logic          aclk = 1'b0, reset = 1'b1;
    logic [DW-1:0] adc_data_a = '0, adc_data_b = '0;
    logic          adc_valid = 1'b0, adc_or = 1'b0;
    logic [31:0]   s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0;
    logic [2:0]    s_axi_awprot = '0, s_axi_arprot = '0;
    logic [3:0]    s_axi_wstrb = '0;
    logic          s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
    logic          s_axi_arvalid = 1'b0, s_axi_rready = 1'b0, m_axis_tready = 1'b0;
    logic          s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]    s_axi_bresp, s_axi_rresp;
    logic [31:0]   s_axi_rdata;
    logic          adc_ready, m_axis_tvalid_chA, m_axis_tvalid_chB;
    logic [TW-1:0] m_axis_tdata_chA, m_axis_tdata_chB;

    always #5 aclk = ~aclk;

    adc_stream_top #(.DATA_WIDTH(DW), .TDATA_WIDTH(TW)) dut (
        .aclk(aclk), .reset(reset),
        .adc_data_a(adc_data_a), .adc_data_b(adc_data_b), .adc_valid(adc_valid), .adc_or(adc_or),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready), .adc_ready(adc_ready),
        .m_axis_tvalid_chA(m_axis_tvalid_chA), .m_axis_tdata_chA(m_axis_tdata_chA),
        .m_axis_tvalid_chB(m_axis_tvalid_chB), .m_axis_tdata_chB(m_axis_tdata_chB),
        .m_axis_tready(m_axis_tready)
    );

    // Behavioural model state; a register write is announced by the stimulus for the edge it lands on.
    logic        m_en, m_twos, m_sticky, m_ready, m_tv;
    logic [15:0] m_drop, m_a, m_b;
    logic [31:0] m_cnt;
    logic        mw_v = 1'b0;
    logic [31:0] mw_addr = '0, mw_data = '0;
    logic [3:0]  mw_strb = '0;
    logic        chk_en = 1'b0;

    function automatic logic [15:0] conv(input logic [DW-1:0] x, input logic tc);
        if (tc) return 16'(int'(x) - 8192);
        return 16'(x);
    endfunction

    function automatic logic [31:0] model_reg(input logic [31:0] addr);
        case (addr[7:2])
            6'd0:    return {29'd0, m_twos, 1'b0, m_en};
            6'd1:    return {m_drop, 14'd0, m_ready, m_sticky};
            6'd2:    return m_cnt;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge aclk) begin
        if (reset) begin
            m_en <= 0; m_twos <= 0; m_sticky <= 0; m_ready <= 0; m_tv <= 0;
            m_drop <= 0; m_a <= 0; m_b <= 0; m_cnt <= 0;
        end else begin
            m_ready <= m_en;
            if (mw_v && mw_addr[7:2] == 6'd0 && mw_strb[0]) begin
                m_en   <= mw_data[0];
                m_twos <= mw_data[2];
            end
            if (adc_or) m_sticky <= 1'b1;
            else if (mw_v && mw_addr[7:2] == 6'd0 && mw_strb[0] && mw_data[1]) m_sticky <= 1'b0;
            if (m_tv && m_axis_tready) m_cnt <= m_cnt + 1;
            if (adc_valid && m_en && (!m_tv || m_axis_tready)) begin
                m_tv <= 1'b1;
                m_a  <= conv(adc_data_a, m_twos);
                m_b  <= conv(adc_data_b, m_twos);
            end else begin
                if (m_axis_tready) m_tv <= 1'b0;
                if (adc_valid && m_en && m_drop != 16'hFFFF) m_drop <= m_drop + 1;
            end
        end
    end

    // Literal expectations posted by the stimulus, consumed by the compare process.
    string       lit_name [NLIT];
    logic [31:0] lit_act  [NLIT];
    logic [31:0] lit_exp  [NLIT];
    int          lit_posted = 0;
    int          lit_done = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic post(input string n, input logic [31:0] act, input logic [31:0] exp);
        if (lit_posted < NLIT) begin
            lit_name[lit_posted] = n;
            lit_act[lit_posted]  = act;
            lit_exp[lit_posted]  = exp;
            lit_posted++;
        end
    endtask

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge aclk);
            if (chk_en) begin
                check("tvalid_chA", 32'(m_axis_tvalid_chA), 32'(m_tv));
                check("tvalid_chB", 32'(m_axis_tvalid_chB), 32'(m_tv));
                check("adc_ready", 32'(adc_ready), 32'(m_ready));
                if (m_tv) begin
                    check("tdata_chA", 32'(m_axis_tdata_chA), 32'(m_a));
                    check("tdata_chB", 32'(m_axis_tdata_chB), 32'(m_b));
                end
            end
            while (lit_done < lit_posted) begin
                check(lit_name[lit_done], lit_act[lit_done], lit_exp[lit_done]);
                lit_done++;
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic or_hs);
        int k;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        k = 0;
        @(negedge aclk);
        while (!s_axi_awready && k < 20) begin @(negedge aclk); k++; end
        if (!s_axi_awready) post("aw_timeout", 0, 1);
        else begin
            post("wready", 32'(s_axi_wready), 1);
            mw_addr = addr; mw_data = data; mw_strb = strb; mw_v = 1'b1;
            if (or_hs) adc_or = 1'b1;
        end
        tick();
        mw_v = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        if (or_hs) adc_or = 1'b0;
        k = 0;
        @(negedge aclk);
        while (!s_axi_bvalid && k < 20) begin @(negedge aclk); k++; end
        if (!s_axi_bvalid) post("b_timeout", 0, 1);
        post("bresp", 32'(s_axi_bresp), (addr[7:2] < 6'd3) ? 32'd0 : 32'd2);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        int k;
        logic [31:0] exp;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        k = 0;
        exp = 32'hDEAD_BEEF;
        @(negedge aclk);
        while (!s_axi_arready && k < 20) begin @(negedge aclk); k++; end
        if (!s_axi_arready) post("ar_timeout", 0, 1);
        else exp = model_reg(addr);
        tick();
        s_axi_arvalid = 1'b0;
        k = 0;
        @(negedge aclk);
        while (!s_axi_rvalid && k < 20) begin @(negedge aclk); k++; end
        if (!s_axi_rvalid) post("r_timeout", 0, 1);
        data = s_axi_rdata;
        post($sformatf("rdata_%02h", addr[7:0]), s_axi_rdata, exp);
        post($sformatf("rresp_%02h", addr[7:0]), 32'(s_axi_rresp), (addr[7:2] < 6'd3) ? 32'd0 : 32'd2);
        @(negedge aclk);
        post("rdata_hold", s_axi_rdata, data);
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
    endtask

    task automatic drive_one(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [15:0] ea, input logic [15:0] eb, input string n);
        adc_valid = 1'b1; adc_data_a = a; adc_data_b = b;
        tick();
        adc_valid = 1'b0;
        @(negedge aclk);
        post({n, "_a"}, 32'(m_axis_tdata_chA), 32'(ea));
        post({n, "_b"}, 32'(m_axis_tdata_chB), 32'(eb));
        tick();
    endtask

    initial begin
        logic [31:0] d;
        int k;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        post("rst_tvalid", 32'(m_axis_tvalid_chA), 0);
        post("rst_bvalid", 32'(s_axi_bvalid), 0);
        post("rst_rvalid", 32'(s_axi_rvalid), 0);

        // Reset register values and an unmapped read
        axi_read(32'h00, d); post("lit_ctrl0", d, 0);
        axi_read(32'h04, d); post("lit_stat0", d, 0);
        axi_read(32'h08, d); post("lit_cnt0", d, 0);
        axi_read(32'h0C, d); post("lit_unmapped", d, 0);
        axi_write(32'h0C, 32'hFFFF_FFFF, 4'hF, 1'b0);

        // CTRL masking and adc_ready
        axi_write(32'h00, 32'h0123_4561, 4'hF, 1'b0);
        axi_read(32'h00, d); post("lit_ctrl_en", d, 32'h1);
        post("lit_ready_on", 32'(adc_ready), 1);
        axi_write(32'h00, 32'h89AB_CDE2, 4'hF, 1'b0);
        axi_read(32'h00, d); post("lit_ctrl_off", d, 0);
        post("lit_ready_off", 32'(adc_ready), 0);
        axi_write(32'h00, 32'h0000_0001, 4'hE, 1'b0);
        axi_read(32'h00, d); post("lit_wstrb_gate", d, 0);

        // Ramp at full rate
        axi_write(32'h00, 32'h1, 4'h1, 1'b0);
        m_axis_tready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                adc_valid = 1'b1; adc_data_a = DW'(5 + i); adc_data_b = ~DW'(5 + i);
            end else adc_valid = 1'b0;
            @(negedge aclk);
            if (i > 0) begin
                post("ramp_a", 32'(m_axis_tdata_chA), 32'(4 + i));
                post("ramp_b", 32'(m_axis_tdata_chB), 32'({2'b00, ~DW'(4 + i)}));
            end
            tick();
        end
        tick();
        axi_read(32'h08, d); post("lit_cnt_ramp", d, 8);

        // Two's complement conversion at the code extremes
        axi_write(32'h00, 32'h5, 4'h1, 1'b0);
        drive_one(14'h0000, 14'h3FFF, 16'hE000, 16'h1FFF, "twos_lo");
        drive_one(14'h3FFF, 14'h2000, 16'h1FFF, 16'h0000, "twos_hi");

        // 200-cycle stall with continuous input
        axi_write(32'h00, 32'h1, 4'h1, 1'b0);
        tick();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 200; i++) begin
            adc_valid = 1'b1; adc_data_a = DW'(100 + i); adc_data_b = DW'(200 + i);
            tick();
        end
        adc_valid = 1'b0;
        @(negedge aclk);
        post("held_a", 32'(m_axis_tdata_chA), 100);
        post("held_b", 32'(m_axis_tdata_chB), 200);
        tick();
        axi_read(32'h04, d); post("lit_drop199", d, 32'h00C7_0002);
        axi_read(32'h08, d); post("lit_cnt_stall", d, 10);
        m_axis_tready = 1'b1;
        tick(); tick();
        axi_read(32'h08, d); post("lit_cnt_release", d, 11);

        // Overrange sticky: set, hold, clear, and set-wins-over-clear
        adc_or = 1'b1; tick(); adc_or = 1'b0;
        axi_read(32'h04, d); post("lit_or_set", d, 32'h00C7_0003);
        axi_read(32'h04, d); post("lit_or_hold", d, 32'h00C7_0003);
        axi_write(32'h00, 32'h3, 4'h1, 1'b0);
        axi_read(32'h04, d); post("lit_or_clr", d, 32'h00C7_0002);
        axi_write(32'h00, 32'h3, 4'h1, 1'b1);
        axi_read(32'h04, d); post("lit_or_setwins", d, 32'h00C7_0003);

        // Disable while a beat is pending
        m_axis_tready = 1'b0;
        adc_valid = 1'b1; adc_data_a = 14'h0123; adc_data_b = 14'h0321;
        tick();
        adc_valid = 1'b0;
        axi_write(32'h00, 32'h0, 4'h1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            adc_valid = 1'b1; adc_data_a = DW'(i); tick();
        end
        adc_valid = 1'b0;
        @(negedge aclk);
        post("pend_a", 32'(m_axis_tdata_chA), 32'h0123);
        post("pend_valid", 32'(m_axis_tvalid_chB), 1);
        tick();
        axi_read(32'h04, d); post("lit_dis_stat", d, 32'h00C7_0001);
        m_axis_tready = 1'b1;
        tick(); tick();
        axi_read(32'h08, d); post("lit_cnt_dis", d, 12);
        post("lit_idle", 32'(m_axis_tvalid_chA), 0);

        k = 0;
        while (lit_done < lit_posted && k < 10) begin tick(); k++; end
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
